pipe_stage_chain: RTL and testbench

- Parametrised, elastic replacement for the fixed IF_Reg/ID_Reg-style pipeline registers between core stages.
- Holds STAGES register slots of DATA_W payload, each with a valid bit.
- Supports valid/ready flow control with bubble collapsing, global freeze, and per-slot selective flush (e.g. branch-taken kills the IF/ID slots only).
- Sits between any two datapath stages; the core instantiates one chain per stage boundary.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 70 +++++++
 rtl/pipe_stage_chain.sv | 133 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain: stage limit,
// per-slot update operation and the popcount helper used for occupancy and
// kill statistics. Optional statistics are enabled by defining PIPE_STATS_EN.
package pipe_pkg;

  // Largest chain the popcount helper and occupancy logic are sized for.
  localparam int PIPE_MAX_STAGES = 8;
  localparam int PIPE_CNT_W      = $clog2(PIPE_MAX_STAGES + 1);

  // What a slot does on the next rising edge.
  typedef enum logic [1:0] {
    SLOT_HOLD = 2'd0,
    SLOT_LOAD = 2'd1,
    SLOT_KILL = 2'd2
  } slot_op_t;

  // Number of set bits in a (zero-extended) slot vector.
  function automatic logic [PIPE_CNT_W-1:0] popcount(input logic [PIPE_MAX_STAGES-1:0] bits);
    logic [PIPE_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PIPE_MAX_STAGES; i++) begin
      n = n + PIPE_CNT_W'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the chain: a valid bit plus payload. Kill clears the
// valid bit, hold keeps everything, load takes the upstream record. Data is
// only rewritten when a valid payload arrives so idle slots do not toggle.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              hold,
  input  logic              load,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_d
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t    slot_q;
  slot_t    slot_d;
  slot_op_t op;

  // Priority: kill beats hold beats load.
  always_comb begin
    op = SLOT_HOLD;
    if (kill) begin
      op = SLOT_KILL;
    end else if (hold) begin
      op = SLOT_HOLD;
    end else if (load) begin
      op = SLOT_LOAD;
    end
  end

  // Next slot record for the selected operation.
  always_comb begin
    slot_d = slot_q;
    case (op)
      SLOT_KILL: slot_d.valid = 1'b0;
      SLOT_LOAD: begin
        slot_d.valid = src_valid;
        if (src_valid) begin
          slot_d.data = src_data;
        end
      end
      default: slot_d = slot_q;
    endcase
  end

  // Slot register, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign valid_q = slot_q.valid;
  assign data_q  = slot_q.data;
  assign valid_d = slot_d.valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES pipeline register slots with valid/ready flow
// control, bubble collapsing, global freeze and per-slot flush.
// Define PIPE_STATS_EN to add the stall_cnt / kill_cnt statistics ports.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              freeze,
  input  logic [STAGES-1:0] flush_mask,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       kill_cnt
`endif
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [DATA_W-1:0] data_q    [STAGES];
  logic [STAGES-1:0] src_valid;
  logic [DATA_W-1:0] src_data  [STAGES];
  logic [STAGES-1:0] adv;
  logic [CNT_W-1:0]  occupancy_q;
  logic [CNT_W-1:0]  occupancy_d;

  // Advance chain: a slot may move when it is empty or its successor moves.
  // Space freed by a flush is not reused until the following cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  // in_ready is forced low while the chain is held in reset.
  assign in_ready = rst & ~freeze & adv[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      // A payload leaving a flushed slot (or the input while slot 0 is
      // flushed) arrives marked invalid.
      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid & ~flush_mask[0];
        assign src_data[gi]  = in_data;
      end else begin : g_src_prev
        assign src_valid[gi] = valid_q[gi-1] & ~flush_mask[gi-1];
        assign src_data[gi]  = data_q[gi-1];
      end

      pipe_slot #(
        .DATA_W(DATA_W)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .kill     (flush_mask[gi]),
        .hold     (freeze),
        .load     (adv[gi]),
        .src_valid(src_valid[gi]),
        .src_data (src_data[gi]),
        .valid_q  (valid_q[gi]),
        .data_q   (data_q[gi]),
        .valid_d  (valid_d[gi])
      );
    end
  endgenerate

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  // Occupancy follows the next valid vector so it lands on the same edge.
  always_comb begin
    logic [PIPE_MAX_STAGES-1:0] vec;
    vec = '0;
    vec[STAGES-1:0] = valid_d;
    occupancy_d = CNT_W'(popcount(vec));
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] kill_cnt_q;
  logic [31:0] kill_cnt_d;

  // Stall cycles and killed valid payloads; both wrap naturally at 2^32.
  always_comb begin
    logic [PIPE_MAX_STAGES-1:0] killed;
    killed = '0;
    killed[STAGES-1:0] = flush_mask & valid_q;
    stall_cnt_d = stall_cnt_q + 32'(in_valid & ~in_ready);
    kill_cnt_d  = kill_cnt_q + 32'(popcount(killed));
  end

  // Statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed testbench for pipe_stage_chain (DATA_W=32, STAGES=2, CNT_W=4).
// Statistics checks compile in when PIPE_STATS_EN is defined.
module tb_pipe_stage_chain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        freeze;
  logic [1:0]  flush_mask;
  logic [3:0]  occupancy;
`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] kill_cnt;
`endif

  int checks;
  int failures;

  pipe_stage_chain #(
    .DATA_W(32),
    .STAGES(2),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .freeze    (freeze),
    .flush_mask(flush_mask),
    .occupancy (occupancy)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check the output-side view of the chain.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic [3:0] occ);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".out_data"}, out_data, d);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    freeze     = 1'b0;
    flush_mask = 2'b00;

    // Reset state.
    #3;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", out_data, 32'd0);
    check("rst.occupancy", 32'(occupancy), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    #9 rst = 1'b1;
    cyc();

    // Stream 0x100..0x102 at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h100;
    #1 check("stream.in_ready", 32'(in_ready), 32'd1);
    cyc();
    expect_out("stream.c1", 1'b0, 32'h0, 4'd1);
    in_data = 32'h101;
    cyc();
    expect_out("stream.c2", 1'b1, 32'h100, 4'd2);
    in_data = 32'h102;
    cyc();
    expect_out("stream.c3", 1'b1, 32'h101, 4'd2);
    in_valid = 1'b0;
    cyc();
    expect_out("stream.c4", 1'b1, 32'h102, 4'd1);
    cyc();
    expect_out("stream.c5", 1'b0, 32'h0, 4'd0);

    // Backpressure: fill with out_ready low, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h200;
    cyc();
    in_data = 32'h201;
    cyc();
    in_data = 32'h202;
    expect_out("bp.full", 1'b1, 32'h200, 4'd2);
    #1 check("bp.in_ready", 32'(in_ready), 32'd0);
    cyc();
    expect_out("bp.hold", 1'b1, 32'h200, 4'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 check("bp.in_ready_drain", 32'(in_ready), 32'd1);
    cyc();
    expect_out("bp.d1", 1'b1, 32'h201, 4'd1);
    cyc();
    expect_out("bp.d2", 1'b0, 32'h0, 4'd0);

    // Freeze for three cycles mid-stream.
    in_valid = 1'b1;
    in_data  = 32'h300;
    cyc();
    in_data = 32'h301;
    cyc();
    expect_out("frz.pre", 1'b1, 32'h300, 4'd2);
    in_data = 32'h302;
    freeze  = 1'b1;
    #1 check("frz.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out($sformatf("frz.h%0d", i), 1'b1, 32'h300, 4'd2);
    end
    freeze = 1'b0;
    cyc();
    expect_out("frz.r1", 1'b1, 32'h301, 4'd2);
    in_valid = 1'b0;
    cyc();
    expect_out("frz.r2", 1'b1, 32'h302, 4'd1);
    cyc();
    expect_out("frz.r3", 1'b0, 32'h0, 4'd0);

    // Selective flush of slot 0 (slot1=0xB, slot0=0xA).
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB;
    cyc();
    in_data = 32'hA;
    cyc();
    in_valid   = 1'b0;
    flush_mask = 2'b01;
    cyc();
    expect_out("fl0.kept", 1'b1, 32'hB, 4'd1);
    flush_mask = 2'b00;
    out_ready  = 1'b1;
    cyc();
    expect_out("fl0.gone", 1'b0, 32'h0, 4'd0);

    // Flush slot 1 while frozen: slot 1 dies, slot 0 holds.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC;
    cyc();
    in_data = 32'hD;
    cyc();
    in_valid   = 1'b0;
    freeze     = 1'b1;
    flush_mask = 2'b10;
    cyc();
    expect_out("flfrz.kill", 1'b0, 32'h0, 4'd1);
    freeze     = 1'b0;
    flush_mask = 2'b00;
    out_ready  = 1'b1;
    cyc();
    expect_out("flfrz.held", 1'b1, 32'hD, 4'd1);
    cyc();
    expect_out("flfrz.empty", 1'b0, 32'h0, 4'd0);

    // flush_mask[0] drops an accepted input.
    in_valid   = 1'b1;
    in_data    = 32'hE;
    flush_mask = 2'b01;
    #1 check("fldrop.in_ready", 32'(in_ready), 32'd1);
    cyc();
    check("fldrop.occupancy", 32'(occupancy), 32'd0);
    in_valid   = 1'b0;
    flush_mask = 2'b00;
    cyc();
    expect_out("fldrop.none", 1'b0, 32'h0, 4'd0);

    // Asynchronous reset of a full chain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hF0;
    cyc();
    in_data = 32'hF1;
    cyc();
    expect_out("arst.full", 1'b1, 32'hF0, 4'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.occupancy", 32'(occupancy), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_out($sformatf("arst.after%0d", i), 1'b0, 32'h0, 4'd0);
    end

`ifdef PIPE_STATS_EN
    // Statistics: five stalled cycles, then flush two valid slots.
    check("stats.stall0", stall_cnt, 32'd0);
    check("stats.kill0", kill_cnt, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h500;
    cyc();
    in_data = 32'h501;
    cyc();
    in_data = 32'h502;
    for (int i = 0; i < 5; i++) cyc();
    check("stats.stall5", stall_cnt, 32'd5);
    in_valid   = 1'b0;
    flush_mask = 2'b11;
    cyc();
    flush_mask = 2'b00;
    check("stats.kill2", kill_cnt, 32'd2);
    check("stats.stall_keep", stall_cnt, 32'd5);
    check("stats.occupancy", 32'(occupancy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
